lsu_mem_master: RTL

Load/store initiator between the core's memory stage and the byte-addressed data RAM. It accepts one load or store request at a time from the core over a valid/ready handshake. It drives the RAM port (`wmem`, `memc`, `A_Ram`, `Di_Ram`) and samples the RAM's combinational read data `Do_Ram`. It returns a single-cycle response with the load data or an error flag, and it rejects misaligned and out-of-range accesses before they reach the RAM.

---
 rtl/lsu_mem_master.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator between the core memory stage and a byte-addressed RAM.
// Optional macro LSU_MISALIGN_SPLIT_EN: misaligned in-range half/word accesses are split into byte accesses.
module lsu_mem_master #(
    parameter int unsigned ADDR_LIMIT = 256
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wmem,
    output logic [2:0]  memc,
    output logic [31:0] A_Ram,
    output logic [31:0] Di_Ram,
    input  logic [31:0] Do_Ram
);
    localparam int unsigned AW = 32;
    localparam int unsigned EW = AW + 1;

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP, S_SPLIT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
`endif

    state_t          r_state;
    logic            r_we;
    logic            r_rsp_valid;
    logic [AW-1:0]   r_rsp_rdata;
    logic            r_rsp_err;
    logic            r_wmem;
    logic [2:0]      r_memc;
    logic [AW-1:0]   r_a_ram;
    logic [AW-1:0]   r_di_ram;

    logic [EW-1:0]   w_end;
    logic            w_mis;
    logic            w_range_err;
    logic            w_size_err;
    logic            w_reject;
    logic [2:0]      w_memc;

    // Request checks; the end address is computed one bit wider so it cannot wrap
    always_comb begin
        w_end       = {1'b0, req_addr} + (EW'(1) << req_size);
        w_range_err = w_end > EW'(ADDR_LIMIT);
        w_size_err  = req_size == 2'd3;
        w_mis       = ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_SPLIT_EN
        w_reject    = w_range_err || w_size_err;
`else
        w_reject    = w_range_err || w_size_err || w_mis;
`endif
        case (req_size)
            2'd0:    w_memc = (req_we || !req_signed) ? 3'd0 : 3'd3;
            2'd1:    w_memc = (req_we || !req_signed) ? 3'd1 : 3'd4;
            default: w_memc = 3'd2;
        endcase
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    logic            r_signed;
    logic [1:0]      r_size;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   r_wdata;
    logic [1:0]      r_k;
    logic [AW-1:0]   r_buf;
    logic [1:0]      w_k_nxt;
    logic            w_last;
    logic [AW-1:0]   w_asm;
    logic [AW-1:0]   w_split_rdata;

    // Byte-lane assembly for split loads; extension applies once the last byte is in
    always_comb begin
        w_k_nxt = r_k + 2'd1;
        w_last  = r_k == ((r_size == 2'd2) ? 2'd3 : 2'd1);
        w_asm   = r_buf;
        w_asm[{r_k, 3'b000} +: 8] = Do_Ram[7:0];
        if (r_size == 2'd2)
            w_split_rdata = w_asm;
        else if (r_signed)
            w_split_rdata = {{16{w_asm[15]}}, w_asm[15:0]};
        else
            w_split_rdata = {16'b0, w_asm[15:0]};
    end
`endif

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_wmem      <= 1'b0;
            r_memc      <= '0;
            r_a_ram     <= '0;
            r_di_ram    <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_signed    <= 1'b0;
            r_size      <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_k         <= '0;
            r_buf       <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we <= req_we;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_signed <= req_signed;
                        r_size   <= req_size;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
`endif
                        if (w_reject) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        end else if (w_mis) begin
                            r_state  <= S_SPLIT;
                            r_k      <= 2'd0;
                            r_buf    <= '0;
                            r_a_ram  <= req_addr;
                            r_memc   <= 3'd0;
                            r_wmem   <= req_we;
                            r_di_ram <= req_we ? AW'(req_wdata[7:0]) : '0;
`endif
                        end else begin
                            r_state  <= S_ACCESS;
                            r_a_ram  <= req_addr;
                            r_memc   <= w_memc;
                            r_wmem   <= req_we;
                            r_di_ram <= req_we ? req_wdata : '0;
                        end
                    end
                end
                S_ACCESS: begin
                    r_state     <= S_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= r_we ? '0 : Do_Ram;
                    r_wmem      <= 1'b0;
                    r_memc      <= '0;
                    r_a_ram     <= '0;
                    r_di_ram    <= '0;
                end
`ifdef LSU_MISALIGN_SPLIT_EN
                S_SPLIT: begin
                    r_buf <= w_asm;
                    if (w_last) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_we ? '0 : w_split_rdata;
                        r_wmem      <= 1'b0;
                        r_memc      <= '0;
                        r_a_ram     <= '0;
                        r_di_ram    <= '0;
                    end else begin
                        r_k      <= w_k_nxt;
                        r_a_ram  <= r_addr + AW'(w_k_nxt);
                        r_di_ram <= r_we ? AW'(r_wdata[{w_k_nxt, 3'b000} +: 8]) : '0;
                    end
                end
`endif
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = RESET && (r_state == S_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign wmem      = r_wmem;
    assign memc      = r_memc;
    assign A_Ram     = r_a_ram;
    assign Di_Ram    = r_di_ram;

endmodule
